trace_deframer: RTL and testbench

TRACE_DEFRAMER -- requirements
Module: trace_deframer

---
 rtl/trace_deframer.sv | 138 +++++++++++++
 tb/tb_trace_deframer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/trace_deframer.sv
// trace_deframer: assembles tagged trace beats into records and queues them in a small FIFO
module trace_deframer #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic [2:0] in_type,
    input  logic       in_valid,
    output logic       rec_valid,
    input  logic       rec_ready,
    output logic [7:0] rec_opcode,
    output logic [7:0] rec_op_a,
    output logic [7:0] rec_op_b,
    output logic [7:0] rec_result,
    output logic [7:0] rec_pc,
    output logic       rec_carry,
    output logic       rec_borrow,
    output logic       seq_err,
    output logic       ovf,
    output logic [7:0] rec_count,
    output logic [7:0] drop_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {HUNT, COLLECT} state_t;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] op_a;
        logic [7:0] op_b;
        logic [7:0] result;
        logic       carry;
        logic       borrow;
        logic [7:0] pc;
    } rec_t;

    state_t        state_q, state_d;
    logic [2:0]    exp_q, exp_d;
    rec_t          cur_q, cur_d;
    logic          seq_err_q, seq_err_d;
    logic          ovf_q;
    logic          push, pop, full, do_push, drop;
    rec_t          mem_q [DEPTH];
    rec_t          head;
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic [7:0]    rec_count_q, drop_count_q;

    // Beat sequencing: match the expected tag, restart on an opcode, otherwise resynchronise
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        cur_d     = cur_q;
        seq_err_d = 1'b0;
        push      = 1'b0;
        if (in_valid) begin
            if (state_q == COLLECT && in_type == exp_q) begin
                exp_d = exp_q + 3'd1;
                case (in_type)
                    3'd1: cur_d.op_a = in_data;
                    3'd2: cur_d.op_b = in_data;
                    3'd3: cur_d.result = in_data;
                    3'd4: cur_d.carry = in_data[0];
                    3'd5: cur_d.borrow = in_data[0];
                    3'd6: begin
                        cur_d.pc = in_data;
                        push     = 1'b1;
                        state_d  = HUNT;
                        exp_d    = 3'd0;
                    end
                    default: ;
                endcase
            end else begin
                seq_err_d = state_q == COLLECT;
                state_d   = HUNT;
                exp_d     = 3'd0;
                if (in_type == 3'd0) begin
                    cur_d        = '0;
                    cur_d.opcode = in_data;
                    exp_d        = 3'd1;
                    state_d      = COLLECT;
                end
            end
        end
    end

    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign pop     = rec_ready && rec_valid;
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    // Sequencer state, FIFO pointers, pulses and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            exp_q        <= 3'd0;
            cur_q        <= '0;
            seq_err_q    <= 1'b0;
            ovf_q        <= 1'b0;
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            rec_count_q  <= 8'd0;
            drop_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            cur_q        <= cur_d;
            seq_err_q    <= seq_err_d;
            ovf_q        <= drop;
            wr_q         <= do_push ? wr_q + AW'(1) : wr_q;
            rd_q         <= pop ? rd_q + AW'(1) : rd_q;
            cnt_q        <= cnt_q + (AW+1)'(do_push) - (AW+1)'(pop);
            rec_count_q  <= do_push ? rec_count_q + 8'd1 : rec_count_q;
            drop_count_q <= (drop && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
        end
    end

    // Record storage; contents need no reset because the head is masked when empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= cur_d;
    end

    assign rec_valid  = cnt_q != '0;
    assign head       = rec_valid ? mem_q[rd_q] : '0;
    assign rec_opcode = head.opcode;
    assign rec_op_a   = head.op_a;
    assign rec_op_b   = head.op_b;
    assign rec_result = head.result;
    assign rec_carry  = head.carry;
    assign rec_borrow = head.borrow;
    assign rec_pc     = head.pc;
    assign seq_err    = seq_err_q;
    assign ovf        = ovf_q;
    assign rec_count  = rec_count_q;
    assign drop_count = drop_count_q;
endmodule

// File: tb/tb_trace_deframer.sv
// tb_trace_deframer: directed self-checking bench for trace_deframer
module tb_trace_deframer;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic [2:0] in_type;
    logic       in_valid;
    logic       rec_valid;
    logic       rec_ready;
    logic [7:0] rec_opcode, rec_op_a, rec_op_b, rec_result, rec_pc;
    logic       rec_carry, rec_borrow;
    logic       seq_err, ovf;
    logic [7:0] rec_count, drop_count;
    logic [7:0] seq_cnt = 8'd0;
    logic [7:0] seq_snap;
    int         tests = 0;
    int         fails = 0;

    trace_deframer #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_type(in_type), .in_valid(in_valid),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_opcode(rec_opcode), .rec_op_a(rec_op_a), .rec_op_b(rec_op_b),
        .rec_result(rec_result), .rec_pc(rec_pc),
        .rec_carry(rec_carry), .rec_borrow(rec_borrow),
        .seq_err(seq_err), .ovf(ovf), .rec_count(rec_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Count seq_err pulses independently of the directed checks
    always @(negedge clk) if (seq_err === 1'b1) seq_cnt <= seq_cnt + 8'd1;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic beat(input logic [2:0] t, input logic [7:0] d);
        in_valid = 1'b1;
        in_type  = t;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        rec_ready = 1'b1;
        @(negedge clk);
        rec_ready = 1'b0;
    endtask

    task automatic send(input logic [7:0] op, input logic rdy);
        beat(3'd0, op);
        beat(3'd1, op + 8'd1);
        beat(3'd2, op + 8'd2);
        beat(3'd3, op + 8'd3);
        beat(3'd4, 8'h01);
        beat(3'd5, 8'h00);
        rec_ready = rdy;
        beat(3'd6, op + 8'd4);
        rec_ready = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [7:0] op);
        chk1({tag, ".valid"}, rec_valid, 1'b1);
        chk8({tag, ".opcode"}, rec_opcode, op);
        chk8({tag, ".op_a"}, rec_op_a, op + 8'd1);
        chk8({tag, ".op_b"}, rec_op_b, op + 8'd2);
        chk8({tag, ".result"}, rec_result, op + 8'd3);
        chk1({tag, ".carry"}, rec_carry, 1'b1);
        chk1({tag, ".borrow"}, rec_borrow, 1'b0);
        chk8({tag, ".pc"}, rec_pc, op + 8'd4);
    endtask

    initial begin
        rst = 1'b1; rec_ready = 1'b0;
        in_valid = 1'b1; in_type = 3'd0; in_data = 8'hAA;
        idle(2);
        rst = 1'b0; in_valid = 1'b0;
        chk1("rst.valid", rec_valid, 1'b0);
        chk8("rst.opcode", rec_opcode, 8'h00);
        chk1("rst.seq_err", seq_err, 1'b0);
        chk1("rst.ovf", ovf, 1'b0);
        chk8("rst.rec_count", rec_count, 8'd0);
        chk8("rst.drop_count", drop_count, 8'd0);
        for (int i = 1; i < 7; i++) beat(3'(i), 8'h33);
        chk1("rstbeat.valid", rec_valid, 1'b0);
        chk8("rstbeat.seq", seq_cnt, 8'd0);
        // basic record
        beat(3'd0, 8'h11); beat(3'd1, 8'h05); beat(3'd2, 8'hFD);
        beat(3'd3, 8'h02); beat(3'd4, 8'h01); beat(3'd5, 8'h00);
        chk1("basic.pre_valid", rec_valid, 1'b0);
        beat(3'd6, 8'h07);
        chk1("basic.valid", rec_valid, 1'b1);
        chk8("basic.opcode", rec_opcode, 8'h11);
        chk8("basic.op_a", rec_op_a, 8'h05);
        chk8("basic.op_b", rec_op_b, 8'hFD);
        chk8("basic.result", rec_result, 8'h02);
        chk1("basic.carry", rec_carry, 1'b1);
        chk1("basic.borrow", rec_borrow, 1'b0);
        chk8("basic.pc", rec_pc, 8'h07);
        chk8("basic.rec_count", rec_count, 8'd1);
        idle(2);
        chk8("basic.stable", rec_opcode, 8'h11);
        pop_one();
        chk1("basic.popped", rec_valid, 1'b0);
        // skipped tag
        beat(3'd0, 8'h20); beat(3'd1, 8'h21); beat(3'd2, 8'h22); beat(3'd4, 8'h01);
        chk1("skip.seq_err", seq_err, 1'b1);
        idle(1);
        chk1("skip.seq_err_end", seq_err, 1'b0);
        chk1("skip.valid", rec_valid, 1'b0);
        beat(3'd0, 8'h21); beat(3'd1, 8'h22); beat(3'd2, 8'h23);
        beat(3'd3, 8'h24); beat(3'd4, 8'h00); beat(3'd5, 8'h01); beat(3'd6, 8'h25);
        chk8("skip2.opcode", rec_opcode, 8'h21);
        chk8("skip2.op_b", rec_op_b, 8'h23);
        chk1("skip2.carry", rec_carry, 1'b0);
        chk1("skip2.borrow", rec_borrow, 1'b1);
        chk8("skip2.pc", rec_pc, 8'h25);
        chk8("skip2.rec_count", rec_count, 8'd2);
        chk8("skip2.seq_total", seq_cnt, 8'd1);
        pop_one();
        // opcode restart mid-record
        beat(3'd0, 8'h30); beat(3'd1, 8'h31); beat(3'd0, 8'h40);
        chk1("restart.seq_err", seq_err, 1'b1);
        beat(3'd1, 8'h41);
        chk1("restart.seq_clear", seq_err, 1'b0);
        beat(3'd2, 8'h42); beat(3'd3, 8'h43); beat(3'd4, 8'h03); beat(3'd5, 8'h02); beat(3'd6, 8'h44);
        chk_head("restart", 8'h40);
        chk8("restart.rec_count", rec_count, 8'd3);
        pop_one();
        // illegal tag in COLLECT, then a pop on an empty FIFO
        beat(3'd0, 8'h50); beat(3'd1, 8'h50); beat(3'd7, 8'h00);
        chk1("tag7.seq_err", seq_err, 1'b1);
        pop_one();
        chk1("tag7.valid", rec_valid, 1'b0);
        chk8("tag7.rec_count", rec_count, 8'd3);
        // overflow with rec_ready low
        send(8'h51, 1'b0); send(8'h52, 1'b0);
        chk1("ovf.none", ovf, 1'b0);
        chk8("ovf.pre_count", rec_count, 8'd5);
        send(8'h53, 1'b0);
        chk1("ovf.pulse", ovf, 1'b1);
        chk8("ovf.drop", drop_count, 8'd1);
        chk8("ovf.rec_count", rec_count, 8'd5);
        idle(1);
        chk1("ovf.pulse_end", ovf, 1'b0);
        chk_head("ovf.first", 8'h51);
        pop_one();
        chk_head("ovf.second", 8'h52);
        pop_one();
        chk1("ovf.empty", rec_valid, 1'b0);
        // simultaneous push and pop when full
        send(8'h61, 1'b0); send(8'h62, 1'b0);
        chk8("pp.pre_count", rec_count, 8'd7);
        send(8'h63, 1'b1);
        chk1("pp.ovf", ovf, 1'b0);
        chk8("pp.drop", drop_count, 8'd1);
        chk8("pp.rec_count", rec_count, 8'd8);
        chk_head("pp.head", 8'h62);
        pop_one();
        chk_head("pp.next", 8'h63);
        pop_one();
        chk1("pp.empty", rec_valid, 1'b0);
        // stray tags in HUNT, then a record with idle gaps
        seq_snap = seq_cnt;
        beat(3'd5, 8'h01); beat(3'd6, 8'h02); beat(3'd7, 8'h03);
        beat(3'd0, 8'h91);
        beat(3'd1, 8'h92); idle(1);
        beat(3'd2, 8'h93); idle(2);
        beat(3'd3, 8'h94); idle(3);
        beat(3'd4, 8'h01); idle(1);
        beat(3'd5, 8'h00); idle(2);
        beat(3'd6, 8'h95);
        chk_head("gaps", 8'h91);
        chk8("gaps.seq", seq_cnt, seq_snap);
        chk8("gaps.rec_count", rec_count, 8'd9);
        // drop_count saturation and rec_count wrap
        send(8'hA1, 1'b0);
        for (int i = 0; i < 260; i++) send(8'hB0, 1'b0);
        chk8("sat.drop", drop_count, 8'hFF);
        chk8("sat.rec_count", rec_count, 8'd10);
        chk8("sat.head", rec_opcode, 8'h91);
        for (int i = 0; i < 250; i++) send(8'hC0, 1'b1);
        chk8("wrap.rec_count", rec_count, 8'd4);
        chk8("wrap.drop", drop_count, 8'hFF);
        chk8("wrap.head", rec_opcode, 8'hC0);
        // reset mid-record with a full FIFO; beat during reset ignored
        beat(3'd0, 8'hD1); beat(3'd1, 8'hD2); beat(3'd2, 8'hD3); beat(3'd3, 8'hD4);
        rst = 1'b1; in_valid = 1'b1; in_type = 3'd0; in_data = 8'hEE;
        idle(1);
        rst = 1'b0; in_valid = 1'b0;
        chk1("mrst.valid", rec_valid, 1'b0);
        chk8("mrst.opcode", rec_opcode, 8'h00);
        chk8("mrst.pc", rec_pc, 8'h00);
        chk8("mrst.rec_count", rec_count, 8'd0);
        chk8("mrst.drop", drop_count, 8'd0);
        chk1("mrst.seq_err", seq_err, 1'b0);
        chk1("mrst.ovf", ovf, 1'b0);
        beat(3'd4, 8'h01);
        chk1("mrst.tag4_seq", seq_err, 1'b0);
        chk1("mrst.tag4_valid", rec_valid, 1'b0);
        send(8'hE1, 1'b0);
        chk_head("mrst.rec", 8'hE1);
        chk8("mrst.rec_count2", rec_count, 8'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
